// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared control-word type, bubble constant and forwarding select codes for
// the ID/EX/MEM/WB control pipeline.
package ctrl_pkg;

  localparam int CTRL_REG_ADDR_W = 5;
  localparam int CTRL_ALUOP_W    = 2;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                    branch;
    logic                    mem_read;
    logic                    mem_to_reg;
    logic                    mem_write;
    logic                    alu_src;
    logic                    reg_write;
    logic [CTRL_ALUOP_W-1:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// Decoder-side control inputs and per-stage control/forwarding outputs of the
// control pipeline; slave is the pipeline, master is whoever drives ID.
interface ctrl_pipe_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
);
  logic                  id_valid;
  logic                  id_branch;
  logic                  id_mem_read;
  logic                  id_mem_to_reg;
  logic                  id_mem_write;
  logic                  id_alu_src;
  logic                  id_reg_write;
  logic [ALUOP_W-1:0]    id_alu_op;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  branch_flush;

  logic                  stall_if_id;
  logic                  ex_alu_src;
  logic [ALUOP_W-1:0]    ex_alu_op;
  logic                  ex_branch;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  mem_mem_read;
  logic                  mem_mem_write;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] wb_rd;

  modport master (
    output id_valid, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
           id_alu_src, id_reg_write, id_alu_op, id_rs1, id_rs2, id_uses_rs2,
           id_rd, branch_flush,
    input  stall_if_id, ex_alu_src, ex_alu_op, ex_branch, fwd_a, fwd_b,
           mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_rd
  );

  modport slave (
    input  id_valid, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
           id_alu_src, id_reg_write, id_alu_op, id_rs1, id_rs2, id_uses_rs2,
           id_rd, branch_flush,
    output stall_if_id, ex_alu_src, ex_alu_op, ex_branch, fwd_a, fwd_b,
           mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_rd
  );

endinterface

// File: rtl/ctrl_pipe_hazard_hazard_unit.sv
// Combinational load-use detection against the ID instruction and per-operand
// EX forwarding select (MEM result beats WB result).
module ctrl_hazard_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = CTRL_REG_ADDR_W,
  parameter int NUM_OPS    = 2
) (
  input  logic                                ex_mem_read,
  input  logic [REG_ADDR_W-1:0]               ex_rd,
  input  logic [NUM_OPS-1:0][REG_ADDR_W-1:0]  ex_rs,
  input  logic                                id_valid,
  input  logic [REG_ADDR_W-1:0]               id_rs1,
  input  logic [REG_ADDR_W-1:0]               id_rs2,
  input  logic                                id_uses_rs2,
  input  logic                                mem_reg_write,
  input  logic [REG_ADDR_W-1:0]               mem_rd,
  input  logic                                wb_reg_write,
  input  logic [REG_ADDR_W-1:0]               wb_rd,
  output logic                                load_use,
  output logic [NUM_OPS-1:0][1:0]             fwd
);

  logic mem_live, wb_live;

  // x0 is never a forwarding source even if a writer somehow targets it
  assign mem_live = mem_reg_write && (mem_rd != '0);
  assign wb_live  = wb_reg_write  && (wb_rd  != '0);

  assign load_use = ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    assign fwd[g] = (mem_live && (mem_rd == ex_rs[g])) ? FWD_MEM :
                    (wb_live  && (wb_rd  == ex_rs[g])) ? FWD_WB  : FWD_REG;
  end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline for the 5-stage RV32I core: carries the decoded control word
// ID->EX->MEM->WB, inserts load-use bubbles, applies branch flush, drives forwarding.
module ctrl_pipe_hazard
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = CTRL_REG_ADDR_W,
  parameter int ALUOP_W    = CTRL_ALUOP_W
) (
  input logic               clk,
  input logic               reset,
  ctrl_pipe_hazard_if.slave bus
);

  typedef struct packed {
    ctrl_word_t            ctrl;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } ex_stage_t;

  typedef struct packed {
    ctrl_word_t            ctrl;
    logic [REG_ADDR_W-1:0] rd;
  } late_stage_t;

  ex_stage_t   ex_q, ex_d;
  late_stage_t mem_q, wb_q;
  ctrl_word_t  id_word;
  logic        load_use;
  logic [1:0][1:0] fwd;

  always_comb begin
    id_word            = CTRL_BUBBLE;
    id_word.branch     = bus.id_branch;
    id_word.mem_read   = bus.id_mem_read;
    id_word.mem_to_reg = bus.id_mem_to_reg;
    id_word.mem_write  = bus.id_mem_write;
    id_word.alu_src    = bus.id_alu_src;
    id_word.reg_write  = bus.id_reg_write && (bus.id_rd != '0);
    id_word.alu_op     = CTRL_ALUOP_W'(bus.id_alu_op);

    // flush and load-use both replace the ID instruction with a bubble in EX
    ex_d = '0;
    if (bus.id_valid && !load_use && !bus.branch_flush) begin
      ex_d.ctrl = id_word;
      ex_d.rs1  = bus.id_rs1;
      ex_d.rs2  = bus.id_rs2;
      ex_d.rd   = bus.id_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q       <= ex_d;
      mem_q.ctrl <= ex_q.ctrl;
      mem_q.rd   <= ex_q.rd;
      wb_q       <= mem_q;
    end
  end

  ctrl_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_OPS    (2)
  ) u_hazard (
    .ex_mem_read   (ex_q.ctrl.mem_read),
    .ex_rd         (ex_q.rd),
    .ex_rs         ({ex_q.rs2, ex_q.rs1}),
    .id_valid      (bus.id_valid),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .id_uses_rs2   (bus.id_uses_rs2),
    .mem_reg_write (mem_q.ctrl.reg_write),
    .mem_rd        (mem_q.rd),
    .wb_reg_write  (wb_q.ctrl.reg_write),
    .wb_rd         (wb_q.rd),
    .load_use      (load_use),
    .fwd           (fwd)
  );

  assign bus.stall_if_id   = load_use && !bus.branch_flush;
  assign bus.ex_alu_src    = ex_q.ctrl.alu_src;
  assign bus.ex_alu_op     = ALUOP_W'(ex_q.ctrl.alu_op);
  assign bus.ex_branch     = ex_q.ctrl.branch;
  assign bus.fwd_a         = fwd[0];
  assign bus.fwd_b         = fwd[1];
  assign bus.mem_mem_read  = mem_q.ctrl.mem_read;
  assign bus.mem_mem_write = mem_q.ctrl.mem_write;
  assign bus.wb_reg_write  = wb_q.ctrl.reg_write;
  assign bus.wb_mem_to_reg = wb_q.ctrl.mem_to_reg;
  assign bus.wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: directed scenarios with literal expectations,
// then random instruction streams checked every cycle against a stage-list model.
module tb_ctrl_pipe_hazard;
  import ctrl_pkg::*;

  localparam int RW = 5;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_pipe_hazard_if #(.REG_ADDR_W(RW), .ALUOP_W(AW)) bus ();

  ctrl_pipe_hazard #(.REG_ADDR_W(RW), .ALUOP_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic [4:0] rd;
  } instr_t;

  int     errors = 0;
  int     checks = 0;
  instr_t cur = '0;
  bit     flush = 1'b0;
  // model: what instruction each stage holds ('0 is a bubble)
  instr_t m_ex = '0, m_mem = '0, m_wb = '0;

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t rtype(int rd, int rs1, int rs2);
    instr_t i = '0;
    i.valid = 1; i.reg_write = 1; i.alu_op = 2'b10; i.uses_rs2 = 1;
    i.rd = rd[4:0]; i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
    return i;
  endfunction

  function automatic instr_t lw(int rd, int rs1);
    instr_t i = '0;
    i.valid = 1; i.mem_read = 1; i.mem_to_reg = 1; i.alu_src = 1; i.reg_write = 1;
    i.rd = rd[4:0]; i.rs1 = rs1[4:0];
    return i;
  endfunction

  function automatic instr_t sw(int rs1, int rs2);
    instr_t i = '0;
    i.valid = 1; i.mem_write = 1; i.alu_src = 1; i.uses_rs2 = 1;
    i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
    return i;
  endfunction

  function automatic instr_t beq(int rs1, int rs2);
    instr_t i = '0;
    i.valid = 1; i.branch = 1; i.alu_op = 2'b01; i.uses_rs2 = 1;
    i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.valid      = ($urandom_range(7) != 0);
    i.branch     = ($urandom_range(5) == 0);
    i.mem_read   = ($urandom_range(2) == 0);
    i.mem_to_reg = $urandom_range(1);
    i.mem_write  = ($urandom_range(4) == 0);
    i.alu_src    = $urandom_range(1);
    i.reg_write  = ($urandom_range(3) != 0);
    i.alu_op     = 2'($urandom_range(3));
    i.rs1        = 5'($urandom_range(7));
    i.rs2        = 5'($urandom_range(7));
    i.uses_rs2   = $urandom_range(1);
    i.rd         = 5'($urandom_range(7));
    return i;
  endfunction

  task automatic put(instr_t i, bit fl);
    cur = i; flush = fl;
    bus.id_valid      = i.valid;
    bus.id_branch     = i.branch;
    bus.id_mem_read   = i.mem_read;
    bus.id_mem_to_reg = i.mem_to_reg;
    bus.id_mem_write  = i.mem_write;
    bus.id_alu_src    = i.alu_src;
    bus.id_reg_write  = i.reg_write;
    bus.id_alu_op     = i.alu_op;
    bus.id_rs1        = i.rs1;
    bus.id_rs2        = i.rs2;
    bus.id_uses_rs2   = i.uses_rs2;
    bus.id_rd         = i.rd;
    bus.branch_flush  = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    put(nop(), 1'b0);
    repeat (3) tick();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({bus.stall_if_id, bus.ex_alu_src, bus.ex_alu_op, bus.ex_branch,
                bus.fwd_a, bus.fwd_b, bus.mem_mem_read, bus.mem_mem_write,
                bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd});
  endfunction

  // a load in EX whose destination the ID instruction reads
  function automatic bit m_load_use();
    return m_ex.mem_read && (m_ex.rd != 0) && cur.valid &&
           ((m_ex.rd == cur.rs1) || (cur.uses_rs2 && (m_ex.rd == cur.rs2)));
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] rs);
    if (rs != 0 && m_mem.reg_write && m_mem.rd == rs) return 2'b10;
    if (rs != 0 && m_wb.reg_write  && m_wb.rd  == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    instr_t nx;
    nx = cur;
    nx.reg_write = cur.reg_write && (cur.rd != 0);
    if (!cur.valid || flush || m_load_use()) nx = '0;
    if (reset) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else begin
      m_wb = m_mem; m_mem = m_ex; m_ex = nx;
    end
  end

  always @(negedge clk) begin
    chk("stall_if_id",   bus.stall_if_id,   32'(m_load_use() && !flush));
    chk("ex_alu_src",    bus.ex_alu_src,    32'(m_ex.alu_src));
    chk("ex_alu_op",     bus.ex_alu_op,     32'(m_ex.alu_op));
    chk("ex_branch",     bus.ex_branch,     32'(m_ex.branch));
    chk("fwd_a",         bus.fwd_a,         32'(m_fwd(m_ex.rs1)));
    chk("fwd_b",         bus.fwd_b,         32'(m_fwd(m_ex.rs2)));
    chk("mem_mem_read",  bus.mem_mem_read,  32'(m_mem.mem_read));
    chk("mem_mem_write", bus.mem_mem_write, 32'(m_mem.mem_write));
    chk("wb_reg_write",  bus.wb_reg_write,  32'(m_wb.reg_write));
    chk("wb_mem_to_reg", bus.wb_mem_to_reg, 32'(m_wb.mem_to_reg));
    chk("wb_rd",         bus.wb_rd,         32'(m_wb.rd));
  end

  initial begin
    instr_t nxt;
    bit     hold;

    // reset held over two edges with a live R-type at ID
    reset = 1'b1;
    put(rtype(3, 1, 2), 1'b0);
    @(negedge clk);
    chk("t1_reset_outs", outs_vec(), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    tick(); put(nop(), 1'b0);
    @(negedge clk);
    chk("t1_ex_alu_op", bus.ex_alu_op, 32'h2);
    tick(); tick();
    @(negedge clk);
    chk("t1_wb_reg_write", bus.wb_reg_write, 32'h1);
    chk("t1_wb_rd", bus.wb_rd, 32'h3);

    // lw x5 ; add x6,x5,x7
    drain();
    put(lw(5, 1), 1'b0); tick();
    put(rtype(6, 5, 7), 1'b0);
    @(negedge clk);
    chk("t2_stall", bus.stall_if_id, 32'h1);
    tick();
    @(negedge clk);
    chk("t2_stall_once", bus.stall_if_id, 32'h0);
    chk("t2_ex_bubble", {bus.ex_alu_src, bus.ex_alu_op, bus.ex_branch}, 32'h0);
    chk("t2_lw_in_mem", bus.mem_mem_read, 32'h1);
    tick(); put(nop(), 1'b0);
    @(negedge clk);
    chk("t2_fwd_a", bus.fwd_a, 32'h1);
    chk("t2_fwd_b", bus.fwd_b, 32'h0);

    // back-to-back dependency, then one-apart dependency
    drain();
    put(rtype(3, 1, 2), 1'b0); tick();
    put(rtype(4, 3, 3), 1'b0); tick();
    put(nop(), 1'b0);
    @(negedge clk);
    chk("t3_fwd_a_mem", bus.fwd_a, 32'h2);
    chk("t3_fwd_b_mem", bus.fwd_b, 32'h2);
    drain();
    put(rtype(3, 1, 2), 1'b0); tick();
    put(nop(), 1'b0); tick();
    put(rtype(4, 3, 9), 1'b0); tick();
    put(nop(), 1'b0);
    @(negedge clk);
    chk("t3_fwd_a_wb", bus.fwd_a, 32'h1);
    chk("t3_fwd_b_wb", bus.fwd_b, 32'h0);

    // writes to x0 are dropped and never forwarded
    drain();
    put(rtype(0, 1, 2), 1'b0); tick();
    put(rtype(5, 0, 0), 1'b0); tick();
    put(nop(), 1'b0);
    @(negedge clk);
    chk("t4_fwd_a_x0", bus.fwd_a, 32'h0);
    chk("t4_fwd_b_x0", bus.fwd_b, 32'h0);
    tick();
    @(negedge clk);
    chk("t4_wb_no_write", bus.wb_reg_write, 32'h0);

    // flush during a load-use hazard
    drain();
    put(lw(5, 1), 1'b0); tick();
    put(rtype(6, 5, 7), 1'b1);
    @(negedge clk);
    chk("t5_no_stall", bus.stall_if_id, 32'h0);
    tick(); put(nop(), 1'b0);
    @(negedge clk);
    chk("t5_lw_mem", bus.mem_mem_read, 32'h1);
    chk("t5_ex_bubble", {bus.ex_alu_src, bus.ex_alu_op, bus.ex_branch}, 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("t5_killed_no_wb", bus.wb_reg_write, 32'h0);
    put(beq(1, 2), 1'b0); tick();
    put(rtype(7, 1, 1), 1'b1);
    @(negedge clk);
    chk("t5_branch_ex", bus.ex_branch, 32'h1);
    tick(); put(nop(), 1'b0);
    @(negedge clk);
    chk("t5_branch_left_ex", bus.ex_branch, 32'h0);

    // reset with a store sitting in MEM
    drain();
    put(sw(1, 2), 1'b0); tick();
    put(nop(), 1'b0); tick();
    @(negedge clk);
    chk("t6_sw_mem", bus.mem_mem_write, 32'h1);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_sw_dropped", bus.mem_mem_write, 32'h0);
    reset = 1'b0;
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("t6_no_late_write", bus.mem_mem_write, 32'h0);
    end

    // random streams; a stalled ID instruction is re-presented
    tick();
    nxt = rand_instr();
    for (int n = 0; n < 600; n++) begin
      put(nxt, ($urandom_range(7) == 0));
      reset = ($urandom_range(79) == 0);
      @(negedge clk);
      hold = m_load_use() && !flush && !reset;
      tick();
      if (!hold) nxt = rand_instr();
    end
    reset = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
